// File: rtl/db_dram_resp.sv
// DRAM-port responder: on-chip word store with a fixed-latency read pipeline, post-reset clear sweep and debug counters.
// Optional per-word even parity with error injection when DB_DRAM_PARITY_EN is defined.
module db_dram_resp #(
    parameter int RAM_ADDR   = 22,
    parameter int RAM_DWIDTH = 32,
    parameter int MEM_DEPTH  = 1024,
    parameter int RD_LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  dram_wr_en,
    input  logic [RAM_DWIDTH-1:0] dram_wr_din,
    input  logic [RAM_ADDR-1:0]   dram_addr,
    input  logic                  dram_rd_en,
    output logic [RAM_DWIDTH-1:0] dram_rd_dout,
    output logic                  dram_rd_valid,
    output logic                  init_done,
    output logic                  addr_err,
    output logic [15:0]           rd_cnt,
    output logic [15:0]           wr_cnt,
    output logic [15:0]           drop_cnt
`ifdef DB_DRAM_PARITY_EN
    ,
    input  logic                  par_inject,
    output logic                  par_err
`endif
);

    localparam int IDX_W = $clog2(MEM_DEPTH);
`ifdef DB_DRAM_PARITY_EN
    localparam int MW = RAM_DWIDTH + 1;
`else
    localparam int MW = RAM_DWIDTH;
`endif

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [0:0]       state;
    logic [IDX_W-1:0] clr_ptr;
    logic [MW-1:0]    mem [MEM_DEPTH];

    logic                  in_range;
    logic [IDX_W-1:0]      idx;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [MW-1:0]         wr_word;
    logic [MW-1:0]         cap_word;
    logic                  mem_we;
    logic [IDX_W-1:0]      mem_wa;
    logic [MW-1:0]         mem_wd;

    logic [RD_LATENCY-1:0] pipe_vld;
    logic [RAM_DWIDTH-1:0] pipe_data [RD_LATENCY];
`ifdef DB_DRAM_PARITY_EN
    logic [RD_LATENCY-1:0] pipe_perr;
    logic                  cap_perr;
`endif

    assign in_range = (dram_addr >> IDX_W) == '0;
    assign idx      = dram_addr[IDX_W-1:0];
    assign wr_acc   = (state == ST_READY) && dram_wr_en;
    assign rd_acc   = (state == ST_READY) && dram_rd_en;

`ifdef DB_DRAM_PARITY_EN
    assign wr_word = {(^dram_wr_din) ^ par_inject, dram_wr_din};
`else
    assign wr_word = dram_wr_din;
`endif

    // Clear sweep owns the write port during INIT; afterwards in-range writes only.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = clr_ptr;
        mem_wd = '0;
        if (state == ST_INIT) begin
            mem_we = 1'b1;
        end else if (wr_acc && in_range) begin
            mem_we = 1'b1;
            mem_wa = idx;
            mem_wd = wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_wa] <= mem_wd;
    end

    // Write-first: a same-cycle write (always to the shared address) bypasses the array.
    always_comb begin
        cap_word = '0;
        if (in_range)
            cap_word = wr_acc ? wr_word : mem[idx];
    end

`ifdef DB_DRAM_PARITY_EN
    assign cap_perr = in_range && (cap_word[RAM_DWIDTH] != (^cap_word[RAM_DWIDTH-1:0]));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_INIT;
            clr_ptr   <= '0;
            init_done <= 1'b0;
        end else if (state == ST_INIT) begin
            clr_ptr <= clr_ptr + IDX_W'(1);
            if (clr_ptr == '1) begin
                state     <= ST_READY;
                init_done <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt   <= '0;
            wr_cnt   <= '0;
            drop_cnt <= '0;
            addr_err <= 1'b0;
        end else if (state == ST_INIT) begin
            if ((dram_wr_en || dram_rd_en) && drop_cnt != '1)
                drop_cnt <= drop_cnt + 16'd1;
        end else begin
            if (rd_acc)
                rd_cnt <= rd_cnt + 16'd1;
            if (wr_acc)
                wr_cnt <= wr_cnt + 16'd1;
            if ((rd_acc || wr_acc) && !in_range)
                addr_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld <= '0;
            for (int unsigned i = 0; i < RD_LATENCY; i++)
                pipe_data[i] <= '0;
`ifdef DB_DRAM_PARITY_EN
            pipe_perr <= '0;
`endif
        end else begin
            for (int unsigned i = RD_LATENCY - 1; i > 0; i--) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_data[i] <= pipe_data[i-1];
`ifdef DB_DRAM_PARITY_EN
                pipe_perr[i] <= pipe_perr[i-1];
`endif
            end
            pipe_vld[0]  <= rd_acc;
            pipe_data[0] <= rd_acc ? cap_word[RAM_DWIDTH-1:0] : '0;
`ifdef DB_DRAM_PARITY_EN
            pipe_perr[0] <= rd_acc && cap_perr;
`endif
        end
    end

    assign dram_rd_valid = pipe_vld[RD_LATENCY-1];
    assign dram_rd_dout  = pipe_vld[RD_LATENCY-1] ? pipe_data[RD_LATENCY-1] : '0;
`ifdef DB_DRAM_PARITY_EN
    assign par_err = pipe_vld[RD_LATENCY-1] && pipe_perr[RD_LATENCY-1];
`endif

endmodule

// File: tb/tb_db_dram_resp.sv
// Directed bench for db_dram_resp: init sweep, drops, latency, write-first, back-to-back, range errors, reset mid-read.
// Parity scenario is compiled only with DB_DRAM_PARITY_EN.
module tb_db_dram_resp;

    logic        clk;
    logic        rst_n;
    logic        dram_wr_en;
    logic [31:0] dram_wr_din;
    logic [21:0] dram_addr;
    logic        dram_rd_en;
    logic [31:0] dram_rd_dout;
    logic        dram_rd_valid;
    logic        init_done;
    logic        addr_err;
    logic [15:0] rd_cnt;
    logic [15:0] wr_cnt;
    logic [15:0] drop_cnt;
`ifdef DB_DRAM_PARITY_EN
    logic        par_inject;
    logic        par_err;
`endif

    int checks;
    int failures;

    db_dram_resp #(
        .RAM_ADDR  (22),
        .RAM_DWIDTH(32),
        .MEM_DEPTH (1024),
        .RD_LATENCY(4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dram_wr_en   (dram_wr_en),
        .dram_wr_din  (dram_wr_din),
        .dram_addr    (dram_addr),
        .dram_rd_en   (dram_rd_en),
        .dram_rd_dout (dram_rd_dout),
        .dram_rd_valid(dram_rd_valid),
        .init_done    (init_done),
        .addr_err     (addr_err),
        .rd_cnt       (rd_cnt),
        .wr_cnt       (wr_cnt),
        .drop_cnt     (drop_cnt)
`ifdef DB_DRAM_PARITY_EN
        ,
        .par_inject   (par_inject),
        .par_err      (par_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All tasks start and end at a negedge.
    task automatic do_write(input logic [21:0] a, input logic [31:0] d);
        dram_addr   = a;
        dram_wr_din = d;
        dram_wr_en  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dram_wr_en  = 1'b0;
    endtask

    task automatic do_read(input logic [21:0] a, output logic [31:0] d, output int lat);
        dram_addr  = a;
        dram_rd_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dram_rd_en = 1'b0;
        lat = 1;
        while (!dram_rd_valid && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        d = dram_rd_dout;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        dram_wr_en = 1'b0; dram_rd_en = 1'b0;
        dram_wr_din = '0; dram_addr = '0;
`ifdef DB_DRAM_PARITY_EN
        par_inject = 1'b0;
`endif
        repeat (3) @(negedge clk);
        checks++;
        if ({init_done, dram_rd_valid, addr_err} !== 3'b000 || dram_rd_dout !== 32'h0) begin
            failures++;
            $display("FAIL reset_flags: got done/vld/err=%b%b%b dout=%h required 000 dout=0",
                     init_done, dram_rd_valid, addr_err, dram_rd_dout);
        end
        checks++;
        if (rd_cnt !== 16'h0 || wr_cnt !== 16'h0 || drop_cnt !== 16'h0) begin
            failures++;
            $display("FAIL reset_counters: got rd=%h wr=%h drop=%h required all 0", rd_cnt, wr_cnt, drop_cnt);
        end
    endtask

    // Releases reset, issues 3 command cycles during INIT, then times init_done.
    task automatic test_init_drop;
        int  cycles;
        bit  saw_vld;
        logic [31:0] d;
        int  lat;
        saw_vld = 0;
        rst_n = 1'b1;
        dram_addr = 22'd5; dram_wr_din = 32'hFFFF_FFFF;
        dram_rd_en = 1'b1; dram_wr_en = 1'b1;
        cycles = 0;
        while (!init_done && cycles < 2000) begin
            @(posedge clk);
            @(negedge clk);
            cycles++;
            if (cycles == 1) dram_wr_en = 1'b0;
            if (cycles == 3) dram_rd_en = 1'b0;
            if (dram_rd_valid) saw_vld = 1;
        end
        checks++;
        if (cycles !== 1024) begin
            failures++;
            $display("FAIL init_time: got %0d cycles required 1024", cycles);
        end
        checks++;
        if (drop_cnt !== 16'd3 || rd_cnt !== 16'd0 || wr_cnt !== 16'd0) begin
            failures++;
            $display("FAIL init_drop: got drop=%0d rd=%0d wr=%0d required 3/0/0", drop_cnt, rd_cnt, wr_cnt);
        end
        checks++;
        if (saw_vld !== 1'b0) begin
            failures++;
            $display("FAIL init_no_valid: got rd_valid during INIT required none");
        end
        do_read(22'd5, d, lat);
        checks++;
        if (lat !== 4 || d !== 32'h0) begin
            failures++;
            $display("FAIL init_read5: got lat=%0d dout=%h required lat=4 dout=0", lat, d);
        end
    endtask

    task automatic test_write_read;
        logic [31:0] d;
        int lat;
        do_write(22'h10, 32'hDEAD_BEEF);
        do_read(22'h10, d, lat);
        checks++;
        if (lat !== 4 || d !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL wr_rd: got lat=%0d dout=%h required lat=4 dout=deadbeef", lat, d);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (dram_rd_valid !== 1'b0 || dram_rd_dout !== 32'h0) begin
            failures++;
            $display("FAIL single_pulse: got vld=%b dout=%h required 0/0", dram_rd_valid, dram_rd_dout);
        end
        checks++;
        if (wr_cnt !== 16'd1 || rd_cnt !== 16'd2) begin
            failures++;
            $display("FAIL cnt_after_wr_rd: got wr=%0d rd=%0d required 1/2", wr_cnt, rd_cnt);
        end
    endtask

    task automatic test_write_first;
        logic [31:0] d;
        int lat;
        logic [15:0] wr0, rd0;
        wr0 = wr_cnt; rd0 = rd_cnt;
        dram_addr = 22'h20; dram_wr_din = 32'h1234_5678;
        dram_wr_en = 1'b1; dram_rd_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dram_rd_en = 1'b0; dram_wr_din = 32'h0;
        @(posedge clk);
        @(negedge clk);
        dram_wr_en = 1'b0;
        lat = 2;
        while (!dram_rd_valid && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        d = dram_rd_dout;
        checks++;
        if (lat !== 4 || d !== 32'h1234_5678) begin
            failures++;
            $display("FAIL write_first: got lat=%0d dout=%h required lat=4 dout=12345678", lat, d);
        end
        checks++;
        if (wr_cnt !== wr0 + 16'd2 || rd_cnt !== rd0 + 16'd1) begin
            failures++;
            $display("FAIL write_first_cnt: got wr=%0d rd=%0d required %0d/%0d", wr_cnt, rd_cnt, wr0 + 16'd2, rd0 + 16'd1);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] got [8];
        int n;
        int first;
        bit gap;
        for (int i = 0; i < 8; i++)
            do_write(22'(i), 32'(i * 3));
        n = 0; first = -1; gap = 0;
        for (int j = 0; j < 16; j++) begin
            if (dram_rd_valid) begin
                if (first < 0) first = j;
                if (j != first + n) gap = 1;
                if (n < 8) got[n] = dram_rd_dout;
                n++;
            end
            dram_rd_en = (j < 8);
            dram_addr  = 22'(j);
            @(posedge clk);
            @(negedge clk);
        end
        checks++;
        if (n !== 8 || first !== 4 || gap !== 1'b0) begin
            failures++;
            $display("FAIL b2b_timing: got n=%0d first=%0d gap=%b required 8/4/0", n, first, gap);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (got[i] !== 32'(i * 3)) begin
                failures++;
                $display("FAIL b2b_data[%0d]: got %h required %h", i, got[i], 32'(i * 3));
            end
        end
    endtask

    task automatic test_range_err;
        logic [31:0] d;
        int lat;
        logic [15:0] rd0, wr0;
        rd0 = rd_cnt; wr0 = wr_cnt;
        checks++;
        if (addr_err !== 1'b0) begin
            failures++;
            $display("FAIL addr_err_pre: got %b required 0", addr_err);
        end
        do_write(22'h400, 32'hCAFE_F00D);
        do_read(22'h400, d, lat);
        checks++;
        if (lat !== 4 || d !== 32'h0 || addr_err !== 1'b1) begin
            failures++;
            $display("FAIL oob_read: got lat=%0d dout=%h err=%b required 4/0/1", lat, d, addr_err);
        end
        do_read(22'h0, d, lat);
        checks++;
        if (d !== 32'h0 || addr_err !== 1'b1) begin
            failures++;
            $display("FAIL oob_write_alias: got dout=%h err=%b required 0/1", d, addr_err);
        end
        checks++;
        if (rd_cnt !== rd0 + 16'd2 || wr_cnt !== wr0 + 16'd1) begin
            failures++;
            $display("FAIL oob_cnt: got rd=%0d wr=%0d required %0d/%0d", rd_cnt, wr_cnt, rd0 + 16'd2, wr0 + 16'd1);
        end
    endtask

`ifdef DB_DRAM_PARITY_EN
    task automatic test_parity;
        logic [31:0] d;
        int lat;
        par_inject = 1'b1;
        do_write(22'h30, 32'h0000_0007);
        par_inject = 1'b0;
        do_read(22'h30, d, lat);
        checks++;
        if (par_err !== 1'b1 || d !== 32'h7) begin
            failures++;
            $display("FAIL par_inject: got par_err=%b dout=%h required 1/7", par_err, d);
        end
        do_read(22'h10, d, lat);
        checks++;
        if (par_err !== 1'b0 || d !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL par_clean: got par_err=%b dout=%h required 0/deadbeef", par_err, d);
        end
    endtask
`endif

    task automatic test_reset_mid_read;
        int  cycles;
        bit  saw_vld;
        dram_addr = 22'h10; dram_rd_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dram_rd_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        saw_vld = 0;
        for (int i = 0; i < 6; i++) begin
            if (dram_rd_valid) saw_vld = 1;
            @(negedge clk);
        end
        checks++;
        if (saw_vld !== 1'b0 || rd_cnt !== 16'h0 || wr_cnt !== 16'h0 || drop_cnt !== 16'h0
            || addr_err !== 1'b0 || init_done !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: got vld_seen=%b rd=%0d wr=%0d drop=%0d err=%b done=%b required all 0",
                     saw_vld, rd_cnt, wr_cnt, drop_cnt, addr_err, init_done);
        end
        rst_n = 1'b1;
        cycles = 0;
        while (!init_done && cycles < 2000) begin
            @(posedge clk);
            @(negedge clk);
            cycles++;
            if (dram_rd_valid) saw_vld = 1;
        end
        checks++;
        if (cycles !== 1024 || saw_vld !== 1'b0) begin
            failures++;
            $display("FAIL reinit: got %0d cycles vld_seen=%b required 1024/0", cycles, saw_vld);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset;
        test_init_drop;
        test_write_read;
        test_write_first;
        test_back_to_back;
        test_range_err;
`ifdef DB_DRAM_PARITY_EN
        test_parity;
`endif
        test_reset_mid_read;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
